// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: opcodes, FSM states,
// instruction field positions and error codes.
package alu_issue_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// NREGS x 32 register file: two operand reads, one debug read, one write.
// Register 0 always reads zero and silently drops writes.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dbg_data,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    // Synchronous write; r0 is never updated
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding a combinational ALU, one instruction in flight.
// Optional ALU_FLAGS_EN adds registered zero/negative result flags.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IW = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [IW-1:0]   instr,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ext_we,
    input  logic [AW-1:0]   ext_addr,
    input  logic [XLEN-1:0] ext_wdata,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code
`ifdef ALU_FLAGS_EN
    ,
    output logic            flag_z,
    output logic            flag_n
`endif
);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   instr_q;
    logic [XLEN-1:0] result;
    logic            div0;

    logic [3:0]      opcode;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            unused_low;

    assign opcode = instr_q[OP_LSB +: 4];
    assign rd     = instr_q[RD_LSB +: AW];
    assign rs1    = instr_q[RS1_LSB +: AW];
    assign rs2    = instr_q[RS2_LSB +: AW];
    assign unused_low = ^instr_q[RS2_LSB-1:0];

    // WB and external loads never collide: one is WB-only, the other IDLE-only
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ext_addr;
        rf_wdata = ext_wdata;
        if (state == WB) begin
            rf_we    = !div0;
            rf_waddr = rd;
            rf_wdata = result;
        end else if (state == IDLE) begin
            rf_we    = ext_we;
        end
    end

    alu_issue_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .dbg_addr (dbg_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = DECODE;
            end
            DECODE: state_next = op_legal(opcode) ? EXEC : IDLE;
            EXEC:   state_next = WB;
            WB:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch instruction, drive ALU, capture result, retire pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= 4'b0000;
            result   <= '0;
            div0     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            unique case (state)
                IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                DECODE: begin
                    if (op_legal(opcode)) begin
                        alu_a   <= rs1_data;
                        alu_b   <= rs2_data;
                        alu_sel <= opcode;
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_ILLEGAL;
                    end
                end
                EXEC: begin
                    result <= alu_result;
                    div0   <= (alu_sel == OP_DIV) && (alu_b == '0);
                end
                WB: begin
                    if (div0) begin
                        err      <= 1'b1;
                        err_code <= ERR_DIV0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    // Flags follow successful retires only and hold across errors
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == WB && !div0) begin
            flag_z <= (result == '0);
            flag_n <= result[XLEN-1];
        end
    end
`endif

endmodule
